// File: rtl/cpu_step_controller_pkg.sv
// Shared definitions for the CPU run/single-step controller: state encoding
// and default parameter values.
package cpu_step_controller_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    STEP_ARMED = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 20'd500000;
  localparam int unsigned DEFAULT_CNT_W           = 32;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stable-count filter: db takes the
// synchronized value only after it has differed from db for DEBOUNCE_CYCLES cycles.
module input_debouncer
  import cpu_step_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic raw,
  output logic db
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // any cycle where the input agrees with db restarts the count
      if (sync[1] != db) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          db  <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_step_controller.sv
// Run/single-step controller issuing one-cycle CPU enable pulses per slow-clock
// rise (RUN) or per step press (STEP_ARMED). Pulse counter built only when
// CPU_STEP_COUNTER_EN is defined; otherwise out_cycle_count is tied to 0.
module cpu_step_controller
  import cpu_step_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic             in_clock,
  input  logic             in_reset_n,
  input  logic             in_slow_clock,
  input  logic             in_run_sw,
  input  logic             in_step_btn,
  input  logic             in_halt,
  output logic             out_cpu_en,
  output logic             out_running,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_cycle_count
);

  logic       run_db, step_db, step_prev, step_press;
  logic [1:0] slow_sync;
  logic       slow_prev, tick;
  state_t     state, state_next;
  logic       en_next;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .gclk(in_clock), .grst_n(in_reset_n), .raw(in_run_sw), .db(run_db)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .gclk(in_clock), .grst_n(in_reset_n), .raw(in_step_btn), .db(step_db)
  );

  assign tick       = slow_sync[1] & ~slow_prev;
  assign step_press = step_db & ~step_prev;

  // priority: halt, then run switch, then tick / step press
  always_comb begin
    state_next = state;
    en_next    = 1'b0;
    case (state)
      IDLE: begin
        if (in_halt)         state_next = HALTED;
        else if (run_db)     state_next = RUN;
        else if (step_press) state_next = STEP_ARMED;
      end
      RUN: begin
        if (in_halt)      state_next = HALTED;
        else if (!run_db) state_next = IDLE;
        else if (tick)    en_next    = 1'b1;
      end
      STEP_ARMED: begin
        if (in_halt)     state_next = HALTED;
        else if (run_db) state_next = RUN;
        else if (tick) begin
          en_next    = 1'b1;
          state_next = IDLE;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state       <= IDLE;
      slow_sync   <= '0;
      slow_prev   <= 1'b0;
      step_prev   <= 1'b0;
      out_cpu_en  <= 1'b0;
      out_running <= 1'b0;
      out_halted  <= 1'b0;
    end else begin
      state       <= state_next;
      slow_sync   <= {slow_sync[0], in_slow_clock};
      slow_prev   <= slow_sync[1];
      step_prev   <= step_db;
      out_cpu_en  <= en_next;
      out_running <= (state_next == RUN);
      out_halted  <= (state_next == HALTED);
    end
  end

`ifdef CPU_STEP_COUNTER_EN
  // counts on the same edge the pulse is issued, so it includes the visible pulse
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n)  out_cycle_count <= '0;
    else if (en_next) out_cycle_count <= out_cycle_count + CNT_W'(1);
  end
`else
  assign out_cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller: expected pulses are queued when the
// slow clock is driven and matched by a monitor when out_cpu_en appears.
module tb_cpu_step_controller;
  import cpu_step_controller_pkg::*;

  localparam int unsigned DB  = 4;
  localparam int unsigned CW  = 4;
  localparam int          HALF = 5;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          slow = 1'b0, run_sw = 1'b0, step_btn = 1'b0, halt = 1'b0;
  logic          cpu_en, running, halted;
  logic [CW-1:0] cycle_count;

  typedef struct { int cyc; logic [CW-1:0] cnt; } exp_t;
  exp_t          sb[$];
  logic [CW-1:0] model_cnt = '0;
  int            cyc = 0;
  int            n_checks = 0, n_pass = 0;
  logic          prev_en = 1'b0;

  cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .in_clock(clk), .in_reset_n(rst_n), .in_slow_clock(slow),
    .in_run_sw(run_sw), .in_step_btn(step_btn), .in_halt(halt),
    .out_cpu_en(cpu_en), .out_running(running), .out_halted(halted),
    .out_cycle_count(cycle_count)
  );

  always #HALF clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [CW-1:0] exp_count();
`ifdef CPU_STEP_COUNTER_EN
    return model_cnt;
`else
    return '0;
`endif
  endfunction

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one slow-clock period (20 in_clock cycles); queue a pulse 3 edges after the rise
  task automatic slow_period(input bit expect_pulse);
    exp_t e;
    slow = 1'b1;
    if (expect_pulse) begin
      model_cnt = model_cnt + 1'b1;
      e.cyc = cyc + 3;
      e.cnt = exp_count();
      sb.push_back(e);
    end
    nclk(10);
    slow = 1'b0;
    nclk(10);
  endtask

  task automatic press_step();
    step_btn = 1'b1; nclk(10);
    step_btn = 1'b0; nclk(10);
  endtask

  // every visible pulse must have been queued, land on time, carry the right
  // count and last exactly one cycle
  always @(negedge clk) begin
    if (rst_n && cpu_en) begin
      check("pulse_expected", 32'(sb.size() > 0), 32'd1);
      check("pulse_width", 32'(prev_en), 32'd0);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_count", 32'(cycle_count), 32'(e.cnt));
      end
    end
    prev_en = cpu_en;
  end

  initial begin
    exp_t e;
    // reset state
    nclk(3);
    check("rst_en", 32'(cpu_en), 0);
    check("rst_running", 32'(running), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_count", 32'(cycle_count), 0);
    rst_n = 1'b1;
    nclk(3);

    // free run: five slow-clock periods
    run_sw = 1'b1; nclk(10);
    check("run_running", 32'(running), 1);
    repeat (5) slow_period(1'b1);
    check("run_count", 32'(cycle_count), 32'(exp_count()));
    check("run_sb_empty", 32'(sb.size()), 0);

    // bouncy step press: exactly one pulse, then back to IDLE
    run_sw = 1'b0; nclk(10);
    check("idle_running", 32'(running), 0);
    step_btn = 1'b1; nclk(1);
    step_btn = 1'b0; nclk(1);
    step_btn = 1'b1; nclk(10);
    slow_period(1'b1);
    slow_period(1'b0);
    step_btn = 1'b0; nclk(10);
    check("step_idle_running", 32'(running), 0);
    check("step_idle_halted", 32'(halted), 0);

    // second press while armed does not queue
    press_step();
    press_step();
    slow_period(1'b1);
    slow_period(1'b0);
    check("step2_count", 32'(cycle_count), 32'(exp_count()));

    // run switch while armed: pending step discarded
    press_step();
    run_sw = 1'b1; nclk(10);
    check("armed_to_run", 32'(running), 1);
    slow_period(1'b1);
    slow_period(1'b1);
    run_sw = 1'b0; nclk(10);
    slow_period(1'b0);
    check("armed_sb_empty", 32'(sb.size()), 0);

    // 17 pulses in total wraps a 4-bit counter to 1
    run_sw = 1'b1; nclk(10);
    repeat (8) slow_period(1'b1);
    check("wrap_count", 32'(cycle_count), 32'(exp_count()));
`ifdef CPU_STEP_COUNTER_EN
    check("wrap_is_one", 32'(cycle_count), 1);
`endif

    // halt in the same cycle as a tick: no pulse, HALTED next edge
    slow = 1'b1; nclk(2);
    halt = 1'b1; nclk(1);
    halt = 1'b0;
    check("halt_halted", 32'(halted), 1);
    check("halt_running", 32'(running), 0);
    nclk(9);
    slow = 1'b0; nclk(10);
    press_step();
    run_sw = 1'b0; nclk(10);
    slow_period(1'b0);
    run_sw = 1'b1; nclk(10);
    slow_period(1'b0);
    press_step();
    slow_period(1'b0);
    check("halt_stays", 32'(halted), 1);
    check("halt_sb_empty", 32'(sb.size()), 0);

    // reset asserted while a pulse is high
    run_sw = 1'b0;
    rst_n = 1'b0; nclk(2);
    rst_n = 1'b1; model_cnt = '0;
    run_sw = 1'b1; nclk(10);
    check("rerun_running", 32'(running), 1);
    slow = 1'b1;
    model_cnt = model_cnt + 1'b1;
    e.cyc = cyc + 3; e.cnt = exp_count();
    sb.push_back(e);
    nclk(3);
    check("pre_rst_en", 32'(cpu_en), 1);
    run_sw = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_en", 32'(cpu_en), 0);
    check("async_rst_running", 32'(running), 0);
    check("async_rst_halted", 32'(halted), 0);
    check("async_rst_count", 32'(cycle_count), 0);
    slow = 1'b0; nclk(3);
    rst_n = 1'b1; nclk(10);
    check("post_rst_running", 32'(running), 0);
    check("post_rst_halted", 32'(halted), 0);
    slow_period(1'b0);
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
